stepper_phase_monitor: RTL and testbench
========================================

// Module: stepper_phase_monitor
// PURPOSE
//  Reader for the 4-bit one-hot stepper drive bus (0001->0010->0100->1000 = forward).
//  Decodes phase transitions into step pulses, direction, signed position and revolution
//  count; flags illegal or skipped phases; reports motor stopped. Sits beside the motor
//  driver on the same bus, feeds platform sequencing and fault logic.
// PARAMETERS
//  POS_W          32         width of position counter (two's complement, wraps)
//  STEPS_PER_REV  200        accepted steps per shaft revolution (>=2)
//  IDLE_CYCLES    1_000_000  clk cycles without an accepted step before stopped=1 (20 ms @50 MHz)
//  FILTER_CYCLES  16         stability window for glitch filter (used only with filter enabled)
// PORTS
//  clk          in   1      50 MHz clock
//  rst          in   1      asynchronous reset, active-high
//  phase_in     in   4      stepper drive bus being monitored
//  clear_pos    in   1      sync pulse: zero position and revolution phase
//  clear_fault  in   1      sync pulse: leave FAULT, forget last phase
//  step_pulse   out  1      1-cycle pulse per accepted step
//  dir          out  1      direction of last accepted step (1=forward)
//  position     out  POS_W  signed step count
//  rev_pulse    out  1      1-cycle pulse on forward revolution wrap
//  stopped      out  1      no accepted step for IDLE_CYCLES
//  fault        out  1      sticky fault flag
//  fault_code   out  2      00 none, 01 illegal code, 10 skipped phase
// BEHAVIOUR
//  - Reset: all outputs 0 except stopped=1; last_phase=0000; state IDLE; idle counter 0.
//  - phase_in registered once (ph_q); decode registered -> step_pulse 2 cycles after phase_in change.
//  - Valid codes: 0000 and the four one-hot codes. Anything else -> FAULT, code 01.
//  - States: IDLE (no reference phase), TRACK (last_phase one-hot), FAULT.
//    IDLE: first one-hot ph_q -> last_phase<=ph_q, TRACK; no step counted. 0000 stays IDLE.
//    TRACK: ph_q==rotl(last_phase) -> forward step: position+1, dir<=1, step_pulse.
//           ph_q==rotr(last_phase) -> reverse step: position-1, dir<=0, step_pulse.
//           ph_q==last_phase or 0000 -> hold (last_phase kept, resume continues sequence).
//           ph_q two positions away -> FAULT, code 10.
//    FAULT: no counting, fault/fault_code held; clear_fault -> IDLE, last_phase<=0000,
//           fault<=0, code<=00. clear_fault in other states: last_phase<=0000, state IDLE.
//  - Revolution index 0..STEPS_PER_REV-1: forward step at STEPS_PER_REV-1 wraps to 0 and
//    pulses rev_pulse same cycle as step_pulse; reverse step at 0 wraps to STEPS_PER_REV-1, no pulse.
//  - position wraps modulo 2^POS_W silently.
//  - clear_pos same cycle as step: clear wins (position=0, index=0, no rev_pulse); step_pulse, dir still update.
//  - clear_fault and illegal code same cycle: fault wins (enters/stays FAULT).
//  - Idle counter resets on each accepted step, else increments, saturating at IDLE_CYCLES;
//    stopped=1 when counter==IDLE_CYCLES; stopped drops the cycle step_pulse asserts.
//  - rst mid-operation: immediate return to reset values, no pulse emitted.
// CONFIGURATION
//  STEPPER_MON_FILTER_EN defined: ph_q only updates after phase_in held identical for
//    FILTER_CYCLES consecutive clocks; glitches shorter than that ignored; latency +FILTER_CYCLES.
//  Undefined: ph_q samples phase_in every cycle; any 1-cycle pattern is decoded.
// STRUCTURE
//  Package stepper_mon_pkg: state enum {IDLE,TRACK,FAULT}, fault code constants
//    FLT_NONE/FLT_ILLEGAL/FLT_SKIP, phase constants PH_A..PH_D, rotl/rotr functions.
//  Sub-module stepper_glitch_filter (4-bit, FILTER_CYCLES), instantiated only under the macro.
// TESTING
//  1 Reset, drive 0001,0010,0100,1000,0001 each 10 clk -> 4 step_pulses, dir=1, position=4.
//  2 From 0001 drive 1000,0100 -> position -2, dir=0; from index 0 no rev_pulse.
//  3 STEPS_PER_REV=4, 8 forward steps -> rev_pulse on 4th and 8th step, position=8.
//  4 In TRACK at 0001 drive 0100 -> fault=1, code=10, further steps ignored; clear_fault
//    then 0010 -> no step (reference only), then 0100 -> one step.
//  5 Drive 0011 -> fault code 01; clear_fault with 0011 still present -> fault stays.
//  6 IDLE_CYCLES=100: stop stepping -> stopped=1 at cycle 100; next step clears it;
//    with STEPPER_MON_FILTER_EN, 3-cycle 0010 glitch on 0001 -> no step_pulse.

Source files
------------

// File: rtl/stepper_mon_pkg.sv
//------------------------------------------------------------------------------
// Module  : stepper_mon_pkg
// Brief   : Shared types, phase constants and rotate helpers for the stepper monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stepper_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_SKIP    = 2'b10;

    localparam logic [3:0] PH_A = 4'b0001;
    localparam logic [3:0] PH_B = 4'b0010;
    localparam logic [3:0] PH_C = 4'b0100;
    localparam logic [3:0] PH_D = 4'b1000;

    // Forward rotation of the drive bus is a left rotate (A->B->C->D->A).
    function automatic logic [3:0] rotl(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    function automatic logic [3:0] rotr(input logic [3:0] p);
        return {p[0], p[3:1]};
    endfunction

    function automatic logic is_onehot(input logic [3:0] p);
        return (p == PH_A) || (p == PH_B) || (p == PH_C) || (p == PH_D);
    endfunction

endpackage : stepper_mon_pkg

`default_nettype wire

// File: rtl/stepper_glitch_filter.sv
//------------------------------------------------------------------------------
// Module  : stepper_glitch_filter
// Brief   : Passes the 4-bit phase bus through only once it has been stable for
//           FILTER_CYCLES consecutive clocks. Used when STEPPER_MON_FILTER_EN is set.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stepper_glitch_filter #(
    parameter int FILTER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    output logic [3:0] phase_o
);

    localparam int               CNT_W   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       cand_q;
    logic [3:0]       out_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts how many consecutive samples have matched cand_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= 4'b0000;
            out_q  <= 4'b0000;
            cnt_q  <= '0;
        end else if (phase_i != cand_q) begin
            cand_q <= phase_i;
            cnt_q  <= CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
                out_q <= phase_i;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == CNT_MAX) begin
                out_q <= cand_q;
            end
        end
    end

    assign phase_o = out_q;

endmodule : stepper_glitch_filter

`default_nettype wire

// File: rtl/stepper_phase_monitor.sv
//------------------------------------------------------------------------------
// Module  : stepper_phase_monitor
// Brief   : Decodes the one-hot stepper drive bus into steps, direction, position,
//           revolution pulses, stop detection and sticky phase faults.
//           Define STEPPER_MON_FILTER_EN to insert the input glitch filter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stepper_phase_monitor
    import stepper_mon_pkg::*;
#(
    parameter int POS_W         = 32,
    parameter int STEPS_PER_REV = 200,
    parameter int IDLE_CYCLES   = 1_000_000,
    parameter int FILTER_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              phase_in,
    input  logic                    clear_pos,
    input  logic                    clear_fault,
    output logic                    step_pulse,
    output logic                    dir,
    output logic signed [POS_W-1:0] position,
    output logic                    rev_pulse,
    output logic                    stopped,
    output logic                    fault,
    output logic [1:0]              fault_code
);

    localparam int                IDX_W    = $clog2(STEPS_PER_REV);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(STEPS_PER_REV - 1);
    localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    if (STEPS_PER_REV < 2) begin : g_chk_spr
        $error("STEPS_PER_REV must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_chk_filter
        $error("FILTER_CYCLES must be at least 1");
    end

    logic [3:0] ph_q;

`ifdef STEPPER_MON_FILTER_EN
    stepper_glitch_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_glitch_filter (
        .clk     (clk),
        .rst     (rst),
        .phase_i (phase_in),
        .phase_o (ph_q)
    );
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q <= 4'b0000;
        end else begin
            ph_q <= phase_in;
        end
    end
`endif

    state_e            state_q;
    logic [3:0]        last_q;
    logic              step_pulse_q;
    logic              dir_q;
    logic [POS_W-1:0]  pos_q;
    logic [IDX_W-1:0]  idx_q;
    logic              rev_pulse_q;
    logic              fault_q;
    logic [1:0]        code_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_d;
    logic              stopped_q;
    logic              stopped_d;

    logic ph_onehot;
    logic ph_illegal;
    logic step_fwd;
    logic step_rev;
    logic step_any;
    logic ph_skip;

    assign ph_onehot  = is_onehot(ph_q);
    assign ph_illegal = (ph_q != 4'b0000) && !ph_onehot;
    // A clear_fault in TRACK drops the reference, so it also suppresses a step.
    assign step_fwd   = (state_q == TRACK) && !clear_fault && (ph_q == rotl(last_q));
    assign step_rev   = (state_q == TRACK) && !clear_fault && (ph_q == rotr(last_q));
    assign step_any   = step_fwd || step_rev;
    assign ph_skip    = ph_onehot && (ph_q != last_q) && !step_fwd && !step_rev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 4'b0000;
            step_pulse_q <= 1'b0;
            dir_q        <= 1'b0;
            pos_q        <= '0;
            idx_q        <= '0;
            rev_pulse_q  <= 1'b0;
            fault_q      <= 1'b0;
            code_q       <= FLT_NONE;
        end else begin
            step_pulse_q <= step_any;
            rev_pulse_q  <= 1'b0;
            if (step_any) begin
                dir_q <= step_fwd;
            end

            if (clear_pos) begin
                pos_q <= '0;
                idx_q <= '0;
            end else if (step_fwd) begin
                pos_q <= pos_q + POS_W'(1);
                if (idx_q == IDX_MAX) begin
                    idx_q       <= '0;
                    rev_pulse_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else if (step_rev) begin
                pos_q <= pos_q - POS_W'(1);
                idx_q <= (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (ph_illegal) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FLT_ILLEGAL;
                    end else if (clear_fault) begin
                        last_q <= 4'b0000;
                    end else if (ph_onehot) begin
                        last_q  <= ph_q;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (ph_illegal) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FLT_ILLEGAL;
                    end else if (clear_fault) begin
                        last_q  <= 4'b0000;
                        state_q <= IDLE;
                    end else if (step_any) begin
                        last_q <= ph_q;
                    end else if (ph_skip) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        code_q  <= FLT_SKIP;
                    end
                end
                FAULT: begin
                    if (clear_fault && !ph_illegal) begin
                        state_q <= IDLE;
                        last_q  <= 4'b0000;
                        fault_q <= 1'b0;
                        code_q  <= FLT_NONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    last_q  <= 4'b0000;
                end
            endcase
        end
    end

    // Stopped is sticky from reset until the first accepted step.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        stopped_d  = stopped_q;
        if (step_any) begin
            idle_cnt_d = '0;
            stopped_d  = 1'b0;
        end else begin
            if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
            stopped_d = stopped_q || (idle_cnt_d == IDLE_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
            stopped_q  <= 1'b1;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            stopped_q  <= stopped_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign dir        = dir_q;
    assign position   = pos_q;
    assign rev_pulse  = rev_pulse_q;
    assign stopped    = stopped_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule : stepper_phase_monitor

`default_nettype wire

// File: tb/tb_stepper_phase_monitor.sv
//------------------------------------------------------------------------------
// Module  : tb_stepper_phase_monitor
// Brief   : Directed scoreboard bench for stepper_phase_monitor (SPR=4, IDLE=100).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stepper_phase_monitor;

    localparam int POS_W = 16;
    localparam int SPR   = 4;
    localparam int IDLE  = 100;
    localparam int FILT  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        phase_in = 4'b0000;
    logic              clear_pos = 1'b0;
    logic              clear_fault = 1'b0;
    logic              step_pulse;
    logic              dir;
    logic [POS_W-1:0]  position;
    logic              rev_pulse;
    logic              stopped;
    logic              fault;
    logic [1:0]        fault_code;

    stepper_phase_monitor #(
        .POS_W         (POS_W),
        .STEPS_PER_REV (SPR),
        .IDLE_CYCLES   (IDLE),
        .FILTER_CYCLES (FILT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .clear_pos   (clear_pos),
        .clear_fault (clear_fault),
        .step_pulse  (step_pulse),
        .dir         (dir),
        .position    (position),
        .rev_pulse   (rev_pulse),
        .stopped     (stopped),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             dir;
        logic [POS_W-1:0] pos;
        logic             rev;
    } step_t;

    step_t      exp_steps[$];
    logic [1:0] exp_faults[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       fault_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation for every step pulse and every fault entry.
    always @(negedge clk) begin
        step_t e;
        if (step_pulse) begin
            if (exp_steps.size() == 0) begin
                check("unexpected_step", 32'd1, 32'd0);
            end else begin
                e = exp_steps.pop_front();
                check("step_dir", 32'(dir), 32'(e.dir));
                check("step_pos", 32'(position), 32'(e.pos));
                check("step_rev", 32'(rev_pulse), 32'(e.rev));
                check("step_stopped", 32'(stopped), 32'd0);
            end
        end else if (rev_pulse) begin
            check("rev_without_step", 32'd1, 32'd0);
        end
        if (fault && !fault_prev) begin
            if (exp_faults.size() == 0) begin
                check("unexpected_fault", 32'(fault_code), 32'hF);
            end else begin
                check("fault_code", 32'(fault_code), 32'(exp_faults.pop_front()));
            end
        end
        fault_prev <= fault;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p);
        phase_in = p;
        cyc(10);
    endtask

    task automatic push(input logic d, input logic [POS_W-1:0] p, input logic r);
        exp_steps.push_back(step_t'{dir: d, pos: p, rev: r});
    endtask

    task automatic pulse_clear_fault();
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_clear_pos();
        clear_pos = 1'b1;
        cyc(1);
        clear_pos = 1'b0;
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [8];
        int         k;
        seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

        // Reset state
        cyc(3);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_rev", 32'(rev_pulse), 32'd0);
        check("rst_stopped", 32'(stopped), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        rst = 1'b0;
        cyc(3);
        check("post_rst_stopped", 32'(stopped), 32'd1);

        // Forward sequence; fourth step wraps the revolution index
        drive(4'b0001);
        push(1'b1, 16'd1, 1'b0); drive(4'b0010);
        push(1'b1, 16'd2, 1'b0); drive(4'b0100);
        push(1'b1, 16'd3, 1'b0); drive(4'b1000);
        push(1'b1, 16'd4, 1'b1); drive(4'b0001);
        check("t1_pos", 32'(position), 32'd4);

        // Reverse from index 0: no revolution pulse
        pulse_clear_pos();
        check("clr_pos", 32'(position), 32'd0);
        push(1'b0, 16'hFFFF, 1'b0); drive(4'b1000);
        push(1'b0, 16'hFFFE, 1'b0); drive(4'b0100);
        check("t2_dir", 32'(dir), 32'd0);

        // Eight forward steps, rev_pulse on the 4th and 8th
        pulse_clear_pos();
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 16'(i + 1), ((i + 1) % 4) == 0);
            drive(seq[i]);
        end
        check("t3_pos", 32'(position), 32'd8);

        // Clear coinciding with a wrapping step: clear wins, no rev_pulse
        push(1'b1, 16'd9, 1'b0);  drive(4'b1000);
        push(1'b1, 16'd10, 1'b0); drive(4'b0001);
        push(1'b1, 16'd11, 1'b0); drive(4'b0010);
        clear_pos = 1'b1;
        push(1'b1, 16'd0, 1'b0);  drive(4'b0100);
        clear_pos = 1'b0;
        push(1'b1, 16'd1, 1'b0);  drive(4'b1000);

        // Skipped phase fault, steps ignored, recovery needs a new reference
        push(1'b1, 16'd2, 1'b0); drive(4'b0001);
        exp_faults.push_back(2'b10);
        drive(4'b0100);
        drive(4'b1000);
        check("skip_fault", 32'(fault), 32'd1);
        check("skip_code", 32'(fault_code), 32'd2);
        drive(4'b0000);
        pulse_clear_fault();
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_code", 32'(fault_code), 32'd0);
        drive(4'b0010);
        push(1'b1, 16'd3, 1'b0); drive(4'b0100);

        // Illegal code; clear_fault while still illegal keeps the fault
        exp_faults.push_back(2'b01);
        drive(4'b0011);
        pulse_clear_fault();
        check("ill_fault_held", 32'(fault), 32'd1);
        check("ill_code_held", 32'(fault_code), 32'd1);
        drive(4'b0000);
        pulse_clear_fault();
        check("ill_cleared", 32'(fault), 32'd0);
        check("ill_code_clr", 32'(fault_code), 32'd0);

        // Stop detection after IDLE cycles without an accepted step
        drive(4'b0001);
        push(1'b1, 16'd4, 1'b1);
        phase_in = 4'b0010;
        for (k = 0; k < 40; k++) begin
            cyc(1);
            if (step_pulse) break;
        end
        check("idle_step_seen", 32'(k < 40), 32'd1);
        cyc(IDLE - 1);
        check("stopped_early", 32'(stopped), 32'd0);
        cyc(1);
        check("stopped_at_idle", 32'(stopped), 32'd1);
        push(1'b1, 16'd5, 1'b0); drive(4'b0100);
        check("stopped_cleared", 32'(stopped), 32'd0);

`ifdef STEPPER_MON_FILTER_EN
        phase_in = 4'b1000;
        cyc(FILT - 1);
        drive(4'b0100);
        check("glitch_pos", 32'(position), 32'd5);
`endif

        // Asynchronous reset mid-operation
        phase_in = 4'b1000;
        cyc(1);
        rst = 1'b1;
        #1;
        check("mid_rst_step", 32'(step_pulse), 32'd0);
        cyc(3);
        check("mid_rst_pos", 32'(position), 32'd0);
        check("mid_rst_stopped", 32'(stopped), 32'd1);
        check("mid_rst_dir", 32'(dir), 32'd0);
        rst = 1'b0;
        cyc(5);

        check("steps_drained", 32'(exp_steps.size()), 32'd0);
        check("faults_drained", 32'(exp_faults.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stepper_phase_monitor

`default_nettype wire
